prog_frame_loader: RTL

Framed program loader between the UART-side byte CDC FIFO and the instruction/data RAM write port. It consumes the FIFO's byte stream (valid/ready), parses frames of sync byte, header (start word address, word count), little-endian data words and checksum. It issues one 32-bit RAM write per assembled word with backpressure and reports per-frame success/failure. Unlike raw streaming, frames place code at any address, and corrupted or truncated transfers are detected.

---
 rtl/prog_frame_loader_pkg.sv | 28 ++
 rtl/prog_frame_timeout.sv | 38 +++
 rtl/prog_frame_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/prog_frame_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_frame_loader_pkg
// Description : Shared types and constants for the framed program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_frame_loader_pkg;

  // Default frame start marker
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Position of each header byte after SYNC
  localparam logic [1:0] HDR_ADDR_L = 2'd0;
  localparam logic [1:0] HDR_ADDR_H = 2'd1;
  localparam logic [1:0] HDR_CNT_L  = 2'd2;
  localparam logic [1:0] HDR_CNT_H  = 2'd3;

  // Loader states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_frame_timeout.sv
`default_nettype none
// ============================================================================
// Module      : prog_frame_timeout
// Description : Inter-byte gap counter. Clears on request, counts while run
//               is high, flags the cycle on which it reaches CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_frame_timeout #(
  parameter int unsigned CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_hit
);

  localparam int unsigned      CNT_W        = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] c_last_count = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Hit fires on the cycle whose closing edge brings the count to CYCLES
  assign o_hit = i_run & ~i_clear & (r_cnt == c_last_count);

  // Gap counter: cleared by accepted bytes / idle, frozen while not running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/prog_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_frame_loader
// Description : Parses SYNC/header/data/checksum frames from a byte stream
//               and issues one 32-bit RAM write per assembled word.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_frame_loader
  import prog_frame_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [7:0]            s_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_ok
);

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_hdr_idx;
  logic [1:0]            r_byte_idx;
  logic [7:0]            r_hdr_lo;
  logic [23:0]           r_shift;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_remaining;
  logic [7:0]            r_sum;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [31:0]           r_wr_data;
  logic                  r_frame_done;
  logic                  r_frame_ok;

  logic        w_acc;
  logic        w_take;
  logic        w_wr_fire;
  logic        w_to_run;
  logic        w_to_clear;
  logic        w_to_hit;
  logic        w_done;
  logic        w_ok;
  logic [7:0]  w_sum_next;
  logic [15:0] w_hdr_word;
  logic [31:0] w_word;

  // w_take: a byte handshake that the parser actually consumes
  assign w_acc      = s_valid & s_ready;
  assign w_take     = w_acc & en;
  assign w_wr_fire  = wr_valid & wr_ready;
  assign w_sum_next = r_sum + s_data;
  assign w_hdr_word = {s_data, r_hdr_lo};
  assign w_word     = {s_data, r_shift};

  // Gap timer runs only while a frame is waiting on the byte stream
  assign w_to_run   = en & ((r_state == ST_HDR) | (r_state == ST_DATA) | (r_state == ST_CSUM));
  assign w_to_clear = w_take | (r_state == ST_IDLE);

  prog_frame_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_to_clear),
    .i_run   (w_to_run),
    .o_hit   (w_to_hit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; en low parks the parser in IDLE
  always_comb begin
    w_next = r_state;
    if (!en) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take && (s_data == SYNC_BYTE)) w_next = ST_HDR;
        end
        ST_HDR: begin
          if (w_to_hit) begin
            w_next = ST_IDLE;
          end else if (w_take && (r_hdr_idx == HDR_CNT_H)) begin
            w_next = (w_hdr_word != 16'd0) ? ST_DATA : ST_CSUM;
          end
        end
        ST_DATA: begin
          if (w_to_hit) begin
            w_next = ST_IDLE;
          end else if (w_take && (r_byte_idx == 2'd3)) begin
            w_next = ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (wr_ready) w_next = (r_remaining != 16'd1) ? ST_DATA : ST_CSUM;
        end
        ST_CSUM: begin
          if (w_to_hit || w_take) w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Output decode; reset holds s_ready low regardless of en
  always_comb begin
    s_ready  = rst_n & (~en | (r_state != ST_WRITE));
    wr_valid = en & (r_state == ST_WRITE);
    busy     = (r_state != ST_IDLE);
    w_done   = en & (((r_state == ST_CSUM) & w_acc) | w_to_hit);
    w_ok     = (r_state == ST_CSUM) & w_acc & (w_sum_next == 8'd0);
  end

  // Datapath: header capture, word assembly, running checksum, frame status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr_idx    <= '0;
      r_byte_idx   <= '0;
      r_hdr_lo     <= '0;
      r_shift      <= '0;
      r_addr       <= '0;
      r_remaining  <= '0;
      r_sum        <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_frame_ok   <= 1'b0;
    end else begin
      r_frame_done <= w_done;
      r_frame_ok   <= w_done & w_ok;
      if (w_take) begin
        case (r_state)
          ST_IDLE: begin
            r_sum      <= '0;
            r_hdr_idx  <= '0;
            r_byte_idx <= '0;
          end
          ST_HDR: begin
            r_sum     <= w_sum_next;
            r_hdr_idx <= r_hdr_idx + 2'd1;
            case (r_hdr_idx)
              HDR_ADDR_L: r_hdr_lo    <= s_data;
              HDR_ADDR_H: r_addr      <= ADDR_WIDTH'(w_hdr_word);
              HDR_CNT_L:  r_hdr_lo    <= s_data;
              HDR_CNT_H:  r_remaining <= w_hdr_word;
              default:    r_hdr_lo    <= r_hdr_lo;
            endcase
          end
          ST_DATA: begin
            r_sum      <= w_sum_next;
            r_byte_idx <= r_byte_idx + 2'd1;
            r_shift    <= w_word[31:8];
            if (r_byte_idx == 2'd3) begin
              r_wr_addr <= r_addr;
              r_wr_data <= w_word;
            end
          end
          default: r_sum <= w_sum_next;
        endcase
      end
      if (w_wr_fire) begin
        r_addr      <= r_addr + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - 16'd1;
      end
    end
  end

  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign frame_done = r_frame_done;
  assign frame_ok   = r_frame_ok;

endmodule
`default_nettype wire
